// File: rtl/if_stage.sv
// if_stage: instruction fetch with a 2-entry prefetch FIFO and a single outstanding imem request.
// Taken branches flush the FIFO and drop any response still in flight for the old path.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipeline_stall,
    input  logic        branch_taken,
    input  logic [5:0]  branch_offset_imm,
    output logic [15:0] instruction,
    output logic [15:0] instruction_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata
);
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    logic        outstanding_q, outstanding_d;
    logic        discard_q, discard_d;
    logic [15:0] req_addr_q, last_pc_q, id_pc_q;
    logic [15:0] instr_q [2];
    logic [15:0] pc_q [2];
    logic        present, pop, push, in_flight, issue, wslot;
    logic [15:0] target;

    always_comb begin
        present       = !rst && count_q != 2'd0 && !branch_taken;
        pop           = present && !pipeline_stall;
        push          = !rst && imem_valid && outstanding_q && !discard_q && !branch_taken;
        in_flight     = outstanding_q && !discard_q && !imem_valid;
        count_d       = branch_taken ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        issue         = !rst && !branch_taken && (!outstanding_q || imem_valid) &&
                        ({1'b0, count_d} + {2'b0, in_flight}) < 3'd2;
        target        = id_pc_q + 16'd1 + {{10{branch_offset_imm[5]}}, branch_offset_imm};
        fetch_pc_d    = branch_taken ? target : issue ? fetch_pc_q + 16'd1 : fetch_pc_q;
        outstanding_d = issue || (outstanding_q && !imem_valid);
        discard_d     = branch_taken ? (outstanding_q && !imem_valid) : (discard_q && !imem_valid);
        // push lands behind whatever survives this cycle's pop
        wslot         = count_q[1] | (count_q[0] & !pop);
        imem_req      = issue;
        imem_addr     = fetch_pc_q;
        instruction   = present ? instr_q[0] : 16'h0000;
        instruction_pc = present ? pc_q[0] : last_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            count_q       <= 2'd0;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            req_addr_q    <= 16'h0000;
            last_pc_q     <= 16'h0000;
            id_pc_q       <= 16'h0000;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            if (issue) req_addr_q <= fetch_pc_q;
            if (present) last_pc_q <= pc_q[0];
            if (pop) id_pc_q <= pc_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (pop) begin
            instr_q[0] <= instr_q[1];
            pc_q[0]    <= pc_q[1];
        end
        if (push) begin
            instr_q[wslot] <= imem_rdata;
            pc_q[wslot]    <= req_addr_q;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count_q == 2'd2));
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: vector table for reset/stream/stall/branch plus directed sequences
// for slow-memory branches, address wrap and reset during an in-flight request.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipeline_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [5:0]  branch_offset_imm = 6'd0;
    logic [15:0] instruction, instruction_pc, imem_addr;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clk(clk), .rst(rst), .pipeline_stall(pipeline_stall), .branch_taken(branch_taken),
        .branch_offset_imm(branch_offset_imm), .instruction(instruction),
        .instruction_pc(instruction_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r, s, b;
        logic [5:0] o;
        logic req;
        logic [15:0] addr, instr, pc;
    } vec_t;

    vec_t tbl[$];
    int checks = 0, errors = 0;
    int lat = 1, cnt = 0;
    logic pend = 1'b0, stray = 1'b0, found;
    logic [15:0] paddr = 16'h0000;
    logic s_req;
    logic [15:0] s_addr, s_instr, s_pc;

    task automatic add(input logic r, s, b, input logic [5:0] o, input logic req,
                       input logic [15:0] addr, instr, pc);
        vec_t v;
        v.r = r; v.s = s; v.b = b; v.o = o; v.req = req; v.addr = addr; v.instr = instr; v.pc = pc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic step(input logic r, s, b, input logic [5:0] o);
        @(negedge clk);
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                imem_valid = 1'b1;
                imem_rdata = 16'hA000 | paddr;
                pend = 1'b0;
            end
        end
        if (stray) begin
            imem_valid = 1'b1;
            imem_rdata = 16'hDEAD;
            stray = 1'b0;
        end
        rst = r; pipeline_stall = s; branch_taken = b; branch_offset_imm = o;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_instr = instruction; s_pc = instruction_pc;
        if (s_req) begin
            pend = 1'b1; cnt = lat; paddr = s_addr;
        end
    endtask

    task automatic restart(input int l);
        lat = l;
        pend = 1'b0;
        step(1, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        add(1,0,0,0, 0,16'h0000,16'h0000,16'h0000);
        add(1,0,0,0, 0,16'h0000,16'h0000,16'h0000);
        add(0,0,0,0, 1,16'h0000,16'h0000,16'h0000);
        add(0,0,0,0, 1,16'h0001,16'h0000,16'h0000);
        add(0,0,0,0, 1,16'h0002,16'hA000,16'h0000);
        add(0,0,0,0, 1,16'h0003,16'hA001,16'h0001);
        add(0,0,0,0, 1,16'h0004,16'hA002,16'h0002);
        for (int i = 0; i < 5; i++) add(0,1,0,0, 0,16'h0000,16'hA003,16'h0003);
        add(0,0,0,0, 1,16'h0005,16'hA003,16'h0003);
        for (int i = 0; i < 13; i++)
            add(0,0,0,0, 1, 16'h0006 + 16'(i), 16'hA004 + 16'(i), 16'h0004 + 16'(i));
        add(0,0,1,6'h3C, 0,16'h0000,16'h0000,16'h0010);
        add(0,0,0,0, 1,16'h000D,16'h0000,16'h0010);
        add(0,0,0,0, 1,16'h000E,16'h0000,16'h0010);
        add(0,0,0,0, 1,16'h000F,16'hA00D,16'h000D);
        add(0,0,0,0, 1,16'h0010,16'hA00E,16'h000E);

        restart(1);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].s, tbl[i].b, tbl[i].o);
            chk($sformatf("v%0d req", i), {15'b0, s_req}, {15'b0, tbl[i].req});
            if (tbl[i].req) chk($sformatf("v%0d addr", i), s_addr, tbl[i].addr);
            chk($sformatf("v%0d instr", i), s_instr, tbl[i].instr);
            chk($sformatf("v%0d pc", i), s_pc, tbl[i].pc);
        end

        // branch with a 3-cycle memory and a request outstanding
        restart(3);
        step(0,0,0,0); chk("slow req0", {s_req, s_addr[14:0]}, {1'b1, 15'h0000});
        step(0,0,0,0); chk("slow wait1", {15'b0, s_req}, 16'h0000);
        step(0,0,0,0); chk("slow wait2", {15'b0, s_req}, 16'h0000);
        step(0,0,0,0); chk("slow req1", s_addr, 16'h0001); chk("slow req1 v", {15'b0, s_req}, 16'h0001);
        step(0,0,0,0); chk("slow instr0", s_instr, 16'hA000);
        step(0,0,0,0);
        step(0,0,0,0); chk("slow req2", s_addr, 16'h0002); chk("slow req2 v", {15'b0, s_req}, 16'h0001);
        step(0,0,0,0); chk("slow instr1", s_instr, 16'hA001); chk("slow pc1", s_pc, 16'h0001);
        step(0,0,1,6'd5); chk("slow br req", {15'b0, s_req}, 16'h0000); chk("slow br instr", s_instr, 16'h0000);
        step(0,0,0,0); chk("slow tgt req", {15'b0, s_req}, 16'h0001); chk("slow tgt addr", s_addr, 16'h0007);
        chk("slow stale instr", s_instr, 16'h0000);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(0,0,0,0);
            if (s_instr != 16'h0000) found = 1'b1;
        end
        chk("slow found", {15'b0, found}, 16'h0001);
        chk("slow tgt instr", s_instr, 16'hA007);
        chk("slow tgt pc", s_pc, 16'h0007);

        // address wrap and branch target wrap
        restart(1);
        step(0,0,0,0); step(0,0,0,0);
        step(0,0,0,0); chk("wrap instr0", s_instr, 16'hA000);
        step(0,0,1,6'h3E); chk("wrap br req", {15'b0, s_req}, 16'h0000);
        step(0,0,0,0); chk("wrap addr ffff", s_addr, 16'hFFFF); chk("wrap req ffff", {15'b0, s_req}, 16'h0001);
        step(0,0,0,0); chk("wrap addr 0", s_addr, 16'h0000); chk("wrap req 0", {15'b0, s_req}, 16'h0001);
        step(0,0,0,0); chk("wrap pc ffff", s_pc, 16'hFFFF); chk("wrap instr ffff", s_instr, 16'hFFFF);
        step(0,0,1,6'h3E);
        step(0,0,0,0); chk("wrap addr fffe", s_addr, 16'hFFFE);
        step(0,0,0,0);
        step(0,0,0,0); chk("wrap pc fffe", s_pc, 16'hFFFE);
        step(0,0,1,6'h01); chk("wrap br2 req", {15'b0, s_req}, 16'h0000);
        step(0,0,0,0); chk("wrap tgt addr", s_addr, 16'h0000); chk("wrap tgt req", {15'b0, s_req}, 16'h0001);

        // reset while a request is in flight, then a stray strobe
        restart(1);
        for (int k = 0; k < 4; k++) step(0,0,0,0);
        chk("mid req3", s_addr, 16'h0003);
        step(1,0,0,0); chk("mid rst req", {15'b0, s_req}, 16'h0000); chk("mid rst instr", s_instr, 16'h0000);
        stray = 1'b1;
        step(0,0,0,0); chk("mid first addr", s_addr, 16'h0000); chk("mid first req", {15'b0, s_req}, 16'h0001);
        chk("mid instr a", s_instr, 16'h0000); chk("mid pc a", s_pc, 16'h0000);
        step(0,0,0,0); chk("mid instr b", s_instr, 16'h0000);
        step(0,0,0,0); chk("mid instr c", s_instr, 16'hA000); chk("mid pc c", s_pc, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
